// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and writeback-select stage.
// Captures the MEM-stage instruction, extracts and extends load data,
// selects the writeback value, and drives the register file write port,
// the EX forwarding bus and the retired-instruction counter.
module mem_wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wbsel,
    input  logic [2:0]       mem_funct3,
    input  logic [1:0]       mem_addr_lo,
    input  logic [XLEN-1:0]  mem_alu_out,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  mem_pc,
    input  logic [XLEN-1:0]  mem_imm,
    output logic             rf_load,
    output logic [4:0]       rf_dest,
    output logic [XLEN-1:0]  rf_in,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] WbAlu  = 2'd0;
    localparam logic [1:0] WbLoad = 2'd1;
    localparam logic [1:0] WbPc4  = 2'd2;
    localparam logic [1:0] WbImm  = 2'd3;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    logic             wb_valid;
    logic             wb_regwrite;
    logic [4:0]       wb_rd;
    logic [1:0]       wb_wbsel;
    logic [2:0]       wb_funct3;
    logic [1:0]       wb_addr_lo;
    logic [XLEN-1:0]  wb_alu_out;
    logic [XLEN-1:0]  wb_rdata;
    logic [XLEN-1:0]  wb_pc;
    logic [XLEN-1:0]  wb_imm;
    logic [CNT_W-1:0] instret_cnt;

    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  wb_value;
    logic             write_en;

    // WB pipeline register: stall holds everything, flush inserts a bubble.
    // On flush only wb_valid is cleared; the stale payload cannot write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= 5'd0;
            wb_wbsel    <= 2'd0;
            wb_funct3   <= 3'd0;
            wb_addr_lo  <= 2'd0;
            wb_alu_out  <= '0;
            wb_rdata    <= '0;
            wb_pc       <= '0;
            wb_imm      <= '0;
        end else if (!stall) begin
            if (flush) begin
                wb_valid <= 1'b0;
            end else begin
                wb_valid    <= mem_valid;
                wb_regwrite <= mem_regwrite;
                wb_rd       <= mem_rd;
                wb_wbsel    <= mem_wbsel;
                wb_funct3   <= mem_funct3;
                wb_addr_lo  <= mem_addr_lo;
                wb_alu_out  <= mem_alu_out;
                wb_rdata    <= mem_rdata;
                wb_pc       <= mem_pc;
                wb_imm      <= mem_imm;
            end
        end
    end

    // Retired-instruction counter: one count per instruction leaving WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_cnt <= '0;
        end else if (wb_valid && !stall) begin
            instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

    // Little-endian byte/half extraction and sign/zero extension of load data.
    always_comb begin
        load_byte = 8'h00;
        unique case (wb_addr_lo)
            2'd0: load_byte = wb_rdata[7:0];
            2'd1: load_byte = wb_rdata[15:8];
            2'd2: load_byte = wb_rdata[23:16];
            2'd3: load_byte = wb_rdata[31:24];
            default: load_byte = 8'h00;
        endcase
        // addr_lo[0] is ignored for halfword loads
        load_half = wb_addr_lo[1] ? wb_rdata[31:16] : wb_rdata[15:0];
        case (wb_funct3)
            F3Lb:    load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            F3Lh:    load_data = {{(XLEN-16){load_half[15]}}, load_half};
            F3Lw:    load_data = wb_rdata;
            F3Lbu:   load_data = {{(XLEN-8){1'b0}}, load_byte};
            F3Lhu:   load_data = {{(XLEN-16){1'b0}}, load_half};
            default: load_data = wb_rdata;
        endcase
    end

    // Writeback value select; pc+4 wraps modulo 2^XLEN.
    always_comb begin
        wb_value = wb_alu_out;
        unique case (wb_wbsel)
            WbAlu:   wb_value = wb_alu_out;
            WbLoad:  wb_value = load_data;
            WbPc4:   wb_value = wb_pc + XLEN'(4);
            WbImm:   wb_value = wb_imm;
            default: wb_value = wb_alu_out;
        endcase
    end

    // Register file / forwarding outputs depend only on WB registers.
    // Writes to x0 are suppressed so the bypass never forwards to x0.
    always_comb begin
        write_en  = wb_valid & wb_regwrite & (wb_rd != 5'd0);
        rf_load   = write_en;
        rf_dest   = write_en ? wb_rd : 5'd0;
        rf_in     = wb_value;
        fwd_valid = write_en;
        fwd_rd    = write_en ? wb_rd : 5'd0;
        fwd_data  = wb_value;
        instret   = instret_cnt;
    end

endmodule
